// File: rtl/mux_scan_pkg.sv
// mux_scan_pkg: shared state encodings and channel constants for the mux scan sequencer
package mux_scan_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DONE = 2'd2} state_t;
  localparam logic [1:0] CH0 = 2'b00;
  localparam logic [1:0] CH1 = 2'b01;
  localparam logic [1:0] CH2 = 2'b10;
  localparam logic [1:0] CH3 = 2'b11;
  localparam int NUM_CH = 4;
endpackage

// File: rtl/scan_dwell_counter.sv
// scan_dwell_counter: counts 0..DWELL-1 while enabled, flags the final dwell cycle
module scan_dwell_counter #(
  parameter int DW_W  = 4,
  parameter int DWELL = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic last
);
  logic [DW_W-1:0] cnt;
  assign last = cnt == DW_W'(DWELL - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clear) cnt <= '0;
    else if (enable) cnt <= last ? '0 : cnt + DW_W'(1);
endmodule

// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer: drives a 4:1 mux through all selects and reassembles its output word
module mux_scan_sequencer
  import mux_scan_pkg::*;
#(
  parameter int DWELL = 1,
  parameter int DW_W  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       cont,
  input  logic [3:0] word_in,
  input  logic       mux_out,
  output logic       I0,
  output logic       I1,
  output logic       I2,
  output logic       I3,
  output logic       S0,
  output logic       S1,
  output logic       sel_valid,
  output logic       busy,
  output logic       done,
  output logic [3:0] result,
  output logic       match
);
  if (DWELL < 1 || DWELL > 15 || (1 << DW_W) <= DWELL) begin : g_bad_param
    $error("mux_scan_sequencer: DWELL must be 1..15 and fit in DW_W bits");
  end
  state_t     state, nxt;
  logic [1:0] ch;
  logic [3:0] word;
  logic       last, load, scanning;
  assign load     = (state == IDLE && start) || (state == DONE && cont);
  assign scanning = state == SCAN;
  assign {I3, I2, I1, I0} = word;
  assign {S1, S0} = ch;
  scan_dwell_counter #(.DW_W(DW_W), .DWELL(DWELL)) u_dwell (
    .clk(clk), .rst_n(rst_n), .clear(load), .enable(scanning), .last(last)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  always_comb
    nxt = state == IDLE ? (start ? SCAN : IDLE) :
          state == SCAN ? (last && ch == CH3 ? DONE : SCAN) :
          state == DONE ? (cont ? SCAN : IDLE) : IDLE;
  // the channel only wraps back to CH0 through a fresh load, never inside SCAN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      word   <= '0;
      ch     <= CH0;
      result <= '0;
    end else if (load) begin
      word <= word_in;
      ch   <= CH0;
    end else if (scanning && last) begin
      result[ch] <= mux_out;
      if (ch != CH3) ch <= ch + 2'd1;
    end
  always_comb begin
    sel_valid = state == SCAN;
    busy      = state != IDLE;
    done      = state == DONE;
    match     = done && result == word;
  end
endmodule

// File: doc/mux_scan_sequencer.md
Name: mux_scan_sequencer

Overview:
- Upstream sequencer for the 4:1 mux stage (inputs I0..I3, selects S0/S1, output out).
- On start, it latches a 4-bit word onto I0..I3 and steps the select lines S1:S0 through 00, 01, 10, 11, holding each select for DWELL cycles.
- It samples the mux's out return line for each channel and reports the reassembled 4-bit word with a done pulse.
- This gives an automatic round-trip self-check of the mux channel routing.

Parameters:
- DWELL, 1: clock cycles each select code is held. Legal range is 1..15; elaboration error if outside that range.
- DW_W, 4: width of the dwell counter. Must satisfy 2**DW_W > DWELL.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a scan. Sampled in IDLE only.
- cont  input  1  continuous mode. Sampled in DONE.
- word_in  input  4  data word to route. Latched when a scan begins.
- mux_out  input  1  return from the mux out port.
- I0, I1, I2, I3  output  1 each  mux data inputs. Registered copy of word_in[0..3].
- S0, S1  output  1 each  mux selects. Registered; channel = {S1,S0}.
- sel_valid  output  1  high while in SCAN.
- busy  output  1  high in SCAN and DONE.
- done  output  1  one-cycle pulse, in DONE state.
- result  output  4  sampled word. result[k] = mux_out captured while {S1,S0} = k.
- match  output  1  valid with done: result == latched word.

Behaviour:
- Interface:
  - One clock (clk).
  - Reset rst_n is asynchronous and active-low.
  - All state is in always blocks sensitive to posedge clk or negedge rst_n.
- Reset values: all outputs 0, FSM = IDLE, dwell counter 0, channel index 0.
  - Assertion mid-scan aborts immediately.
  - No done is produced for an aborted scan.
- FSM states:
  - IDLE:
    - start=1 → latch word_in into I0..I3, set {S1,S0}=00, clear dwell counter, go to SCAN.
    - start=0 → stay. Outputs hold their last values; result is retained.
  - SCAN:
    - sel_valid=1.
    - Dwell counter counts 0..DWELL-1.
    - On the cycle where the counter = DWELL-1: result[{S1,S0}] ← mux_out, counter ← 0.
    - If channel = 11 on that cycle, go to DONE; otherwise channel increments.
  - DONE (exactly one cycle):
    - done=1. match = (result == {I3,I2,I1,I0}). result already includes the channel-3 sample.
    - cont=1 → re-latch word_in, channel 00, go to SCAN (back-to-back, no IDLE cycle).
    - cont=0 → go to IDLE.
- Latency: start high at edge t → S=00 visible after t. SCAN occupies 4*DWELL cycles. done is high in cycle t+1+4*DWELL.
- The select code changes only on dwell boundaries. No glitching is permitted, because S0/S1 come straight from flops.
- Sampling happens on the final dwell cycle of each channel. This gives the combinational mux a settle time of DWELL cycles.
- Boundary conditions:
  - start while busy: ignored, no queuing.
  - start and cont both high in DONE: cont governs; start is ignored.
  - word_in changes during SCAN: no effect until the next latch.
  - result bits for channels not yet reached keep their previous-scan values until overwritten. result is fully valid only when done=1.
  - Channel index wraps from 11 to 00 only via DONE; there is never a silent wrap inside SCAN.

Decomposition:
- Package mux_scan_pkg holds:
  - FSM state encodings: IDLE=2'd0, SCAN=2'd1, DONE=2'd2.
  - Channel constants CH0..CH3 = 2'b00..2'b11.
  - NUM_CH = 4.
- One sub-module, scan_dwell_counter:
  - Parameterised DW_W/DWELL.
  - Inputs: clear, enable.
  - Output: last (high when count == DWELL-1).
- The FSM, channel index, input latch and result register stay in the top module.

Test Plan:
- DWELL=1, word_in=4'b1111, mux_out tied to a real mux instance, start pulse at t → S steps 00,01,10,11 at t+1..t+4; done at t+5; result=4'b1111, match=1.
- DWELL=3, word_in=4'b1010 with a real mux → each select held 3 cycles; done at t+13; result=4'b1010, match=1; I0..I3 = 0,1,0,1 throughout.
- Faulty mux model (channel 2 stuck at 0), word_in=4'b0100 → result=4'b0000, match=0 with done.
- cont=1, word_in changed to 4'b0011 during the first scan → second scan starts the cycle after DONE with no idle gap, using 4'b0011; second done gives result=4'b0011.
- start pulsed during SCAN → ignored; done count =1. rst_n low on channel 10 → all outputs 0 asynchronously; no done; the next start scans cleanly from 00.
